// File: rtl/axi_read_responder.sv
// AXI read-side default responder.
// Requests that decode to no mapped slave are held in a small in-order queue.
// Each request is answered with ARLEN+1 beats carrying a fixed RRESP/RDATA,
// with RLAST on the final beat. One idle cycle separates consecutive bursts.
module axi_read_responder #(
    parameter int              ID_WIDTH      = 4,
    parameter int              DATA_WIDTH    = 32,
    parameter int              LEN_WIDTH     = 4,
    parameter int              PENDING_DEPTH = 4,
    parameter logic [1:0]      RESP_CODE     = 2'b11,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = {DATA_WIDTH{1'b0}}
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [LEN_WIDTH-1:0]  ARLEN,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_WIDTH-1:0]   RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int PTR_W = $clog2(PENDING_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PENDING_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Registered state
    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [ID_WIDTH-1:0]  rid_q, rid_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ID_WIDTH-1:0]  id_mem_q  [PENDING_DEPTH];
    logic [ID_WIDTH-1:0]  id_mem_d  [PENDING_DEPTH];
    logic [LEN_WIDTH-1:0] len_mem_q [PENDING_DEPTH];
    logic [LEN_WIDTH-1:0] len_mem_d [PENDING_DEPTH];

    // Combinational helpers
    logic arready_s;
    logic push_s;
    logic pop_s;
    logic rvalid_s;
    logic rlast_s;

    // Acceptance depends only on the registered occupancy, never on RREADY.
    assign arready_s = (count_q != FULL_CNT);
    assign push_s    = ARVALID & arready_s;

    // State register: FSM, beat counter, burst ID, queue pointers and storage.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= {LEN_WIDTH{1'b0}};
            rid_q      <= {ID_WIDTH{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            for (int i = 0; i < PENDING_DEPTH; i++) begin
                id_mem_q[i]  <= {ID_WIDTH{1'b0}};
                len_mem_q[i] <= {LEN_WIDTH{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rid_q      <= rid_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            id_mem_q   <= id_mem_d;
            len_mem_q  <= len_mem_d;
        end
    end

    // Next-state logic: load the queue head in IDLE, count beats down in BURST.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rid_d      = rid_q;
        pop_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != {CNT_W{1'b0}}) begin
                    beat_cnt_d = len_mem_q[rd_ptr_q];
                    rid_d      = id_mem_q[rd_ptr_q];
                    state_d    = ST_BURST;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (RREADY) begin
                    if (beat_cnt_q == {LEN_WIDTH{1'b0}}) begin
                        pop_s   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Queue bookkeeping: pointers wrap naturally, simultaneous push/pop keeps count.
    always_comb begin
        id_mem_d  = id_mem_q;
        len_mem_d = len_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_s) begin
            id_mem_d[wr_ptr_q]  = ARID;
            len_mem_d[wr_ptr_q] = ARLEN;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d            = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Output logic: R channel driven purely from registered state.
    always_comb begin
        rvalid_s = (state_q == ST_BURST);
        if (rvalid_s) begin
            rlast_s = (beat_cnt_q == {LEN_WIDTH{1'b0}});
        end else begin
            rlast_s = 1'b0;
        end
    end

    assign ARREADY = arready_s;
    assign RVALID  = rvalid_s;
    assign RLAST   = rlast_s;
    assign RID     = rid_q;
    assign RDATA   = DEFAULT_DATA;
    assign RRESP   = RESP_CODE;

endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder: directed scenarios plus a
// scoreboard of expected R beats filled on AR acceptance, drained on R handshakes.
module tb_axi_read_responder;

    localparam int IDW  = 4;
    localparam int DW   = 32;
    localparam int LW   = 4;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [IDW-1:0] ARID;
    logic [LW-1:0]  ARLEN;
    logic          ARVALID;
    logic          ARREADY;
    logic [IDW-1:0] RID;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;

    int checks = 0;
    int errors = 0;
    int r_hs   = 0;

    // Expected beats: {id, last}
    logic [IDW:0] sb[$];

    logic          prev_stall = 1'b0;
    logic [IDW-1:0] prev_rid;
    logic          prev_rlast;

    axi_read_responder dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .ARID    (ARID),
        .ARLEN   (ARLEN),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RID     (RID),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RLAST   (RLAST),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor at negedge: inputs are stable, values equal what the next posedge samples.
    always @(negedge ACLK) begin
        logic [IDW:0] e;
        if (ARESET) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_rvalid", RVALID, 1'b1);
                check_eq("stall_rid", RID, prev_rid);
                check_eq("stall_rlast", RLAST, prev_rlast);
            end
            if (RVALID && RREADY) begin
                r_hs++;
                if (sb.size() == 0) begin
                    check_eq("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check_eq("beat_rid", RID, e[IDW:1]);
                    check_eq("beat_rlast", RLAST, e[0]);
                    check_eq("beat_rdata", RDATA, 32'h0);
                    check_eq("beat_rresp", RRESP, 2'b11);
                end
            end
            if (ARVALID && ARREADY) begin
                for (int k = 0; k <= int'(ARLEN); k++) begin
                    sb.push_back({ARID, (k == int'(ARLEN))});
                end
            end
            prev_stall = RVALID && !RREADY;
            prev_rid   = RID;
            prev_rlast = RLAST;
        end
    end

    // Issue one AR and wait (bounded) for acceptance; returns at posedge+1.
    task automatic ar_send(input logic [IDW-1:0] id, input logic [LW-1:0] len);
        logic ok;
        ok = 1'b0;
        ARID    = id;
        ARLEN   = len;
        ARVALID = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge ACLK);
            if (ARREADY) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge ACLK);
        #1;
        ARVALID = 1'b0;
        check_eq("ar_accept", ok, 1'b1);
    endtask

    // Wait (bounded) until every expected beat has been returned.
    task automatic drain(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ACLK);
            if (sb.size() == 0 && !RVALID) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge ACLK);
        #1;
        check_eq("drain", done, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        logic seen_last;
        logic ok;
        logic any_v;

        ARESET = 1'b1; ARID = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check_eq("rst_arready", ARREADY, 1'b1);
        check_eq("rst_rvalid", RVALID, 1'b0);
        check_eq("rst_rlast", RLAST, 1'b0);
        check_eq("rst_rid", RID, 4'h0);
        check_eq("rst_rdata", RDATA, 32'h0);
        check_eq("rst_rresp", RRESP, 2'b11);
        ARESET = 1'b0;
        @(posedge ACLK); #1;

        // 1: single beat, latency N+2
        ar_send(4'd3, 4'd0);
        check_eq("t1_gap", RVALID, 1'b0);
        @(posedge ACLK); #1;
        check_eq("t1_rvalid", RVALID, 1'b1);
        check_eq("t1_rid", RID, 4'd3);
        check_eq("t1_rlast", RLAST, 1'b1);
        check_eq("t1_rresp", RRESP, 2'b11);
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        check_eq("t1_done", RVALID, 1'b0);

        // 2: four consecutive beats
        ar_send(4'd5, 4'd3);
        @(posedge ACLK); #1;
        for (int k = 0; k < 4; k++) begin
            check_eq("t2_rvalid", RVALID, 1'b1);
            check_eq("t2_rid", RID, 4'd5);
            check_eq("t2_rlast", RLAST, (k == 3));
            @(posedge ACLK); #1;
        end
        check_eq("t2_end", RVALID, 1'b0);
        drain(20);

        // 3: fill the queue, fifth request held until first pop
        RREADY = 1'b0;
        for (int i = 1; i <= 4; i++) ar_send(IDW'(i), 4'd1);
        check_eq("t3_full", ARREADY, 1'b0);
        ARID = 4'd5; ARLEN = 4'd1; ARVALID = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check_eq("t3_held", ARREADY, 1'b0);
        RREADY = 1'b1;
        seen_last = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (ARREADY) begin
                ok = 1'b1;
                break;
            end
            seen_last = RVALID && RREADY && RLAST;
        end
        check_eq("t3_ready_seen", ok, 1'b1);
        check_eq("t3_ready_after_last", seen_last, 1'b1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        drain(100);

        // 4: eight beats with random back-pressure
        RREADY = 1'b0;
        base = r_hs;
        ar_send(4'd6, 4'd7);
        for (int i = 0; i < 300; i++) begin
            @(posedge ACLK); #1;
            RREADY = 1'($urandom_range(0, 1));
            if (sb.size() == 0 && !RVALID) break;
        end
        RREADY = 1'b1;
        drain(20);
        check_eq("t4_handshakes", r_hs - base, 8);

        // 5: push coincident with the RLAST handshake at count 1
        RREADY = 1'b0;
        ar_send(4'd7, 4'd0);
        @(posedge ACLK); #1;
        check_eq("t5_first", RVALID, 1'b1);
        ARID = 4'd8; ARLEN = 4'd0; ARVALID = 1'b1; RREADY = 1'b1;
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        check_eq("t5_bubble", RVALID, 1'b0);
        @(posedge ACLK); #1;
        check_eq("t5_next_rvalid", RVALID, 1'b1);
        check_eq("t5_next_rid", RID, 4'd8);
        @(posedge ACLK); #1;
        check_eq("t5_empty", RVALID, 1'b0);
        repeat (3) @(posedge ACLK);
        #1;
        check_eq("t5_no_extra", RVALID, 1'b0);

        // 6: reset in the middle of a burst with two more queued
        RREADY = 1'b0;
        ar_send(4'd10, 4'd3);
        ar_send(4'd11, 4'd1);
        ar_send(4'd12, 4'd1);
        base = r_hs;
        RREADY = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (r_hs - base >= 1) break;
        end
        @(posedge ACLK); #1;
        check_eq("t6_beat2", RVALID, 1'b1);
        ARESET = 1'b1;
        RREADY = 1'b0;
        @(posedge ACLK); #1;
        check_eq("t6_rst_rvalid", RVALID, 1'b0);
        check_eq("t6_rst_arready", ARREADY, 1'b1);
        check_eq("t6_rst_rid", RID, 4'd0);
        ARESET = 1'b0;
        RREADY = 1'b1;
        any_v = 1'b0;
        repeat (10) begin
            @(posedge ACLK); #1;
            any_v = any_v | RVALID;
        end
        check_eq("t6_no_stale", any_v, 1'b0);
        base = r_hs;
        ar_send(4'd9, 4'd0);
        drain(20);
        check_eq("t6_new_hs", r_hs - base, 1);
        check_eq("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
